// File: rtl/cla_seq_pkg.sv
// Shared constants, state encoding and sizing helpers for the nibble-serial adder.
package cla_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int bw);
        return bw / SLICE_W;
    endfunction

    // Counter is at least one bit wide so a single-slice build still has a register.
    function automatic int calc_cnt_w(input int bw);
        int n;
        n = bw / SLICE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_4b.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] cc;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and the slice carry-in.
    assign cc[0] = c;
    assign cc[1] = g[0] | (p[0] & c);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c);

    assign s  = p ^ cc[3:0];
    assign co = cc[4];

endmodule

// File: rtl/cla_seq_add.sv
// Multi-word adder that walks one cla_4b across the operands, LSB nibble first.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_add
    import cla_seq_pkg::*;
#(
    parameter int BW_DATA = 16
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    input  logic               i_c,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [BW_DATA-1:0] o_s,
    output logic               o_c
`ifdef CLA_SEQ_OVF_EN
    ,
    output logic               o_ovf
`endif
);

    localparam int NSLICE = calc_nslice(BW_DATA);
    localparam int CNT_W  = calc_cnt_w(BW_DATA);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_t               state_reg;
    logic [BW_DATA-1:0]   a_reg;
    logic [BW_DATA-1:0]   b_reg;
    logic [BW_DATA-1:0]   s_reg;
    logic                 carry_reg;
    logic [CNT_W-1:0]     cnt_reg;
`ifdef CLA_SEQ_OVF_EN
    logic                 ovf_reg;
`endif

    logic [SLICE_W-1:0]   a_sl [NSLICE];
    logic [SLICE_W-1:0]   b_sl [NSLICE];
    logic [SLICE_W-1:0]   a_cur;
    logic [SLICE_W-1:0]   b_cur;
    logic [SLICE_W-1:0]   slice_s;
    logic                 slice_c;

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign a_cur = a_sl[cnt_reg];
    assign b_cur = b_sl[cnt_reg];

    cla_4b u_cla_slice (
        .a  (a_cur),
        .b  (b_cur),
        .c  (carry_reg),
        .s  (slice_s),
        .co (slice_c)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
`ifdef CLA_SEQ_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_valid) begin
                        a_reg     <= i_a;
                        b_reg     <= i_b;
                        carry_reg <= i_c;
                        cnt_reg   <= '0;
                        s_reg     <= '0;
`ifdef CLA_SEQ_OVF_EN
                        ovf_reg   <= 1'b0;
`endif
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (cnt_reg == CNT_W'(i)) begin
                            s_reg[i*SLICE_W +: SLICE_W] <= slice_s;
                        end
                    end
                    carry_reg <= slice_c;
                    // Counter parks on the last slice instead of wrapping.
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= DONE;
`ifdef CLA_SEQ_OVF_EN
                        ovf_reg   <= (a_reg[BW_DATA-1] == b_reg[BW_DATA-1]) &&
                                     (slice_s[SLICE_W-1] != a_reg[BW_DATA-1]);
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_ready = (state_reg == IDLE);
    assign o_valid = (state_reg == DONE);
    assign o_s     = s_reg;
    assign o_c     = carry_reg;
`ifdef CLA_SEQ_OVF_EN
    assign o_ovf   = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_seq_add.sv
// Scoreboard bench for cla_seq_add: 16-bit main instance plus a 4-bit single-slice instance.
module tb_cla_seq_add;

    localparam int NS = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        i_c = 1'b0;
    logic [15:0] i_a = '0;
    logic [15:0] i_b = '0;
    logic        o_ready, o_valid, o_c;
    logic [15:0] o_s;

    logic        v4 = 1'b0;
    logic        c4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        rdy4, val4, co4;
    logic [3:0]  s4;

`ifdef CLA_SEQ_OVF_EN
    logic        o_ovf, ovf4;
`endif

    cla_seq_add #(.BW_DATA(16)) u_dut (
        .i_clk(clk), .i_rstn(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .o_valid(o_valid), .i_ready(i_ready),
        .o_s(o_s), .o_c(o_c)
`ifdef CLA_SEQ_OVF_EN
        , .o_ovf(o_ovf)
`endif
    );

    cla_seq_add #(.BW_DATA(4)) u_dut4 (
        .i_clk(clk), .i_rstn(rst_n), .i_valid(v4), .o_ready(rdy4),
        .i_a(a4), .i_b(b4), .i_c(c4), .o_valid(val4), .i_ready(1'b1),
        .o_s(s4), .o_c(co4)
`ifdef CLA_SEQ_OVF_EN
        , .o_ovf(ovf4)
`endif
    );

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t q4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor for the 16-bit instance ----------------
    bit          busy = 0, prev_valid = 0, ready_next = 0, have_acc = 0;
    int          acc_cyc = 0, prev_acc = 0;
    logic [15:0] held_s, last_s;
    logic        held_c;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy = 0; prev_valid = 0; ready_next = 0;
        end else begin
            if (ready_next) begin
                chk("ready_after_done", {31'd0, o_ready}, 32'd1);
                chk("sum_hold_idle", {16'd0, o_s}, {16'd0, last_s});
                ready_next = 0;
            end
            if (busy && !o_valid) chk("ready_low_run", {31'd0, o_ready}, 32'd0);
            if (o_valid && !prev_valid) begin
                if (!busy) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    chk("latency", cyc - acc_cyc, NS);
                end
                held_s = o_s;
                held_c = o_c;
            end
            if (o_valid) begin
                chk("sum_stable", {16'd0, o_s}, {16'd0, held_s});
                chk("cout_stable", {31'd0, o_c}, {31'd0, held_c});
                if (i_ready) begin
                    if (q.size() == 0) begin
                        chk("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        $display("txn16: s=%04h c=%0b exp_s=%04h exp_c=%0b", o_s, o_c, e.s, e.c);
                        chk("sum", {16'd0, o_s}, {16'd0, e.s});
                        chk("cout", {31'd0, o_c}, {31'd0, e.c});
`ifdef CLA_SEQ_OVF_EN
                        chk("ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
`endif
                    end
                    busy = 0;
                    ready_next = 1;
                    last_s = o_s;
                end
            end
            if (o_ready && i_valid) begin
                if (have_acc) chk("init_interval", {31'd0, (cyc + 1 - prev_acc) >= NS + 2}, 32'd1);
                acc_cyc = cyc + 1;
                prev_acc = acc_cyc;
                have_acc = 1;
                busy = 1;
            end
            prev_valid = o_valid;
        end
    end

    // ---------------- monitor for the 4-bit instance ----------------
    bit prev4 = 0, busy4 = 0;
    int acc4 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev4 = 0; busy4 = 0;
        end else begin
            if (val4 && !prev4) chk("latency4", cyc - acc4, 1);
            if (val4) begin
                if (q4.size() == 0) begin
                    chk("scoreboard4_empty", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    $display("txn4: s=%01h c=%0b exp_s=%01h exp_c=%0b", s4, co4, e.s[3:0], e.c);
                    chk("sum4", {28'd0, s4}, {28'd0, e.s[3:0]});
                    chk("cout4", {31'd0, co4}, {31'd0, e.c});
`ifdef CLA_SEQ_OVF_EN
                    chk("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
`endif
                end
                busy4 = 0;
            end
            if (rdy4 && v4) begin
                acc4 = cyc + 1;
                busy4 = 1;
            end
            prev4 = val4;
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo, input bit push);
        int n = 0;
        while (!o_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!o_ready) chk("accept_timeout", 32'd1, 32'd0);
        if (push) q.push_back('{s: es, c: ec, ovf: eo});
        i_valid = 1'b1; i_a = a; i_b = b; i_c = c;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] es, input logic ec, input logic eo);
        int n = 0;
        while (!rdy4 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!rdy4) chk("accept4_timeout", 32'd1, 32'd0);
        q4.push_back('{s: {12'd0, es}, c: ec, ovf: eo});
        v4 = 1'b1; a4 = a; b4 = b; c4 = c;
        @(posedge clk); #1;
        v4 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (q.size() != 0 || q4.size() != 0) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_sum", {16'd0, o_s}, 32'd0);
        chk("rst_cout", {31'd0, o_c}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
        chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full ripple, then a back-to-back request exercising the minimum interval
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        send(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1);

        // input isolation: request, operand and i_ready churn during RUN
        send(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            i_valid = 1'b1;
            i_a = 16'($urandom); i_b = 16'($urandom); i_c = 1'($urandom);
            i_ready = ~i_ready;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();

        // backpressure
        i_ready = 1'b0;
        send(16'h8001, 16'h8001, 1'b0, 16'h0002, 1'b1, 1'b1, 1);
        n = 0;
        while (!o_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!o_valid) chk("valid_timeout", 32'd1, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        i_ready = 1'b1;
        send(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1);
        drain();

        // reset mid-operation
        send(16'hAAAA, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        chk("partial_slice0", {16'd0, o_s}, 32'h0000_000F);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, o_s}, 32'd0);
        chk("mid_rst_cout", {31'd0, o_c}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1);

        // signed overflow cases
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);

        // single-slice build
        send4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
        send4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
        send4(4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1);
        send4(4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b0);
        drain();

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
